tdm_demux_4ch: RTL and testbench

- Receive-side counterpart of the 4:1 channel multiplexer.
- Takes a time-division-multiplexed stream of WIDTH-bit beats, one per slot, four slots per frame. Slot 0 is marked by frame_sync.
- Steers each beat to its channel and presents all four channels together, double-buffered, once a complete frame has arrived.
- Sits between the serial link and the per-channel consumers.

---
 rtl/tdm_demux_4ch.sv | 117 +++++++++++
 tb/tb_tdm_demux_4ch.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_4ch.sv
// Four-slot TDM receiver: finds the frame_sync marker, stages slots 0..2, and
// presents all four channels together when slot 3 arrives.
module tdm_demux_4ch #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             frame_sync,
   output logic [WIDTH-1:0] ch0,
   output logic [WIDTH-1:0] ch1,
   output logic [WIDTH-1:0] ch2,
   output logic [WIDTH-1:0] ch3,
   output logic             frame_valid,
   output logic [1:0]       sel,
   output logic             locked,
   output logic             sync_err,
   output logic [CNT_W-1:0] frame_cnt
);

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t           state_q;
   logic [1:0]       sel_q;
   logic [WIDTH-1:0] stage0_q, stage1_q, stage2_q;
   logic [WIDTH-1:0] ch0_q, ch1_q, ch2_q, ch3_q;
   logic             frame_valid_q, locked_q, sync_err_q;
   logic [CNT_W-1:0] frame_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= HUNT;
         sel_q         <= 2'd0;
         stage0_q      <= '0;
         stage1_q      <= '0;
         stage2_q      <= '0;
         ch0_q         <= '0;
         ch1_q         <= '0;
         ch2_q         <= '0;
         ch3_q         <= '0;
         frame_valid_q <= 1'b0;
         locked_q      <= 1'b0;
         sync_err_q    <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
         if (din_valid) begin
            unique case (state_q)
               HUNT: begin
                  // Unsynchronised beats are silently discarded while hunting.
                  if (frame_sync) begin
                     stage0_q <= din;
                     sel_q    <= 2'd1;
                     state_q  <= LOCK;
                     locked_q <= 1'b1;
                  end
               end
               LOCK: begin
                  if (frame_sync) begin
                     // A marker anywhere but slot 0 restarts the frame here.
                     stage0_q <= din;
                     sel_q    <= 2'd1;
                     if (sel_q != 2'd0) begin
                        sync_err_q <= 1'b1;
                     end
                  end else begin
                     unique case (sel_q)
                        2'd0: begin
                           sync_err_q <= 1'b1;
                           state_q    <= HUNT;
                           locked_q   <= 1'b0;
                           sel_q      <= 2'd0;
                        end
                        2'd1: begin
                           stage1_q <= din;
                           sel_q    <= 2'd2;
                        end
                        2'd2: begin
                           stage2_q <= din;
                           sel_q    <= 2'd3;
                        end
                        2'd3: begin
                           ch0_q         <= stage0_q;
                           ch1_q         <= stage1_q;
                           ch2_q         <= stage2_q;
                           ch3_q         <= din;
                           frame_valid_q <= 1'b1;
                           frame_cnt_q   <= frame_cnt_q + CNT_W'(1);
                           sel_q         <= 2'd0;
                        end
                        default: sel_q <= 2'd0;
                     endcase
                  end
               end
               default: state_q <= HUNT;
            endcase
         end
      end
   end

   assign ch0         = ch0_q;
   assign ch1         = ch1_q;
   assign ch2         = ch2_q;
   assign ch3         = ch3_q;
   assign frame_valid = frame_valid_q;
   assign sel         = sel_q;
   assign locked      = locked_q;
   assign sync_err    = sync_err_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed bench for tdm_demux_4ch: framing, error recovery, async reset and
// frame counter wrap, checked with immediate assertions.
module tb_tdm_demux_4ch;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;
   logic       frame_sync = 1'b0;
   logic [7:0] ch0, ch1, ch2, ch3;
   logic       frame_valid, locked, sync_err;
   logic [1:0] sel;
   logic [7:0] frame_cnt;

   int checks = 0;
   int failures = 0;

   tdm_demux_4ch #(.WIDTH(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .frame_sync(frame_sync), .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
      .frame_valid(frame_valid), .sel(sel), .locked(locked),
      .sync_err(sync_err), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ch(input string tag, input logic [31:0] e);
      chk({tag, "_ch"}, {ch0, ch1, ch2, ch3}, e);
   endtask

   // Present one beat; returns 1 time unit after the edge that samples it.
   task automatic beat(input logic [7:0] d, input logic s);
      din = d; din_valid = 1'b1; frame_sync = s;
      @(posedge clk); #1;
      din_valid = 1'b0; frame_sync = 1'b0;
   endtask

   task automatic idle();
      din_valid = 1'b0; frame_sync = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_ch("rst", 32'h0);
      chk("rst_locked", locked, 0);
      chk("rst_sel", sel, 0);
      chk("rst_fv", frame_valid, 0);
      chk("rst_se", sync_err, 0);
      chk("rst_cnt", frame_cnt, 0);
      rst = 1'b0;
      idle();

      // Basic frame
      beat(8'h11, 1);
      chk("f1_locked", locked, 1);
      chk("f1_sel1", sel, 1);
      beat(8'h22, 0);
      beat(8'h33, 0);
      chk_ch("f1_mid", 32'h0);
      chk("f1_sel3", sel, 3);
      beat(8'h44, 0);
      chk_ch("f1", 32'h11223344);
      chk("f1_fv", frame_valid, 1);
      chk("f1_cnt", frame_cnt, 1);
      chk("f1_sel0", sel, 0);
      chk("f1_locked2", locked, 1);
      idle();
      chk("f1_fv_drop", frame_valid, 0);

      // Back-to-back frames, gaps inside frame B
      beat(8'hA1, 1); beat(8'hA2, 0); beat(8'hA3, 0); beat(8'hA4, 0);
      chk_ch("fa", 32'hA1A2A3A4);
      chk("fa_fv", frame_valid, 1);
      chk("fa_cnt", frame_cnt, 2);
      beat(8'hB1, 1);
      chk("fb1_fv", frame_valid, 0);
      idle();
      beat(8'hB2, 0);
      idle(); idle();
      chk("fb_gap_sel", sel, 2);
      beat(8'hB3, 0);
      chk_ch("fb_hold", 32'hA1A2A3A4);
      chk("fb3_fv", frame_valid, 0);
      beat(8'hB4, 0);
      chk_ch("fb", 32'hB1B2B3B4);
      chk("fb_fv", frame_valid, 1);
      chk("fb_cnt", frame_cnt, 3);

      // Slot 0 without sync: lose lock
      beat(8'h99, 0);
      chk("lost_se", sync_err, 1);
      chk("lost_locked", locked, 0);
      chk("lost_sel", sel, 0);
      chk("lost_fv", frame_valid, 0);
      chk_ch("lost_hold", 32'hB1B2B3B4);
      idle();
      chk("lost_se_drop", sync_err, 0);

      // Hunting: unsynced beats dropped quietly, then relock
      beat(8'hAA, 0);
      chk("hunt_se", sync_err, 0);
      beat(8'hBB, 0);
      chk("hunt_locked", locked, 0);
      chk("hunt_sel", sel, 0);
      beat(8'h01, 1); beat(8'h02, 0); beat(8'h03, 0); beat(8'h04, 0);
      chk_ch("relock", 32'h01020304);
      chk("relock_cnt", frame_cnt, 4);

      // Early sync at slot 2
      beat(8'h10, 1); beat(8'h20, 0);
      beat(8'h55, 1);
      chk("early_se", sync_err, 1);
      chk("early_sel", sel, 1);
      chk("early_locked", locked, 1);
      chk_ch("early_hold", 32'h01020304);
      beat(8'h66, 0);
      chk("early_se_drop", sync_err, 0);
      beat(8'h77, 0);
      beat(8'h88, 0);
      chk_ch("early", 32'h55667788);
      chk("early_fv", frame_valid, 1);
      chk("early_se_fv", sync_err, 0);
      chk("early_cnt", frame_cnt, 5);

      // Async reset mid-frame
      beat(8'hC1, 1); beat(8'hC2, 0);
      rst = 1'b1;
      #1;
      chk_ch("arst", 32'h0);
      chk("arst_locked", locked, 0);
      chk("arst_cnt", frame_cnt, 0);
      chk("arst_sel", sel, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      beat(8'hD1, 0);
      chk("post_hunt", locked, 0);
      beat(8'hD2, 1); beat(8'hD3, 0); beat(8'hD4, 0); beat(8'hD5, 0);
      chk_ch("post", 32'hD2D3D4D5);
      chk("post_cnt", frame_cnt, 1);

      // Counter wrap: 254 more frames to 255, then one more to 0
      for (int f = 0; f < 254; f++) begin
         beat(8'(f), 1); beat(8'h00, 0); beat(8'h00, 0); beat(8'hFF, 0);
      end
      chk("cnt_255", frame_cnt, 8'hFF);
      beat(8'hE1, 1); beat(8'hE2, 0); beat(8'hE3, 0); beat(8'hE4, 0);
      chk("cnt_wrap", frame_cnt, 0);
      chk_ch("wrap_ch", 32'hE1E2E3E4);
      chk("wrap_fv", frame_valid, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
